not_sweep_checker: RTL and testbench

// - Self-checking driver/monitor for the parameterised N-bit inverter stage and its verification model.
// - Upstream: drives a common operand onto both the golden model and the inverter under test.
// - Downstream: compares the two results and reports mismatches, the error count and the first failing operand.
// - Sits in the ALU verification harness; one sweep covers all 2^N operands.

---
 rtl/not_sweep_checker.sv | 123 ++++++++++++
 tb/tb_not_sweep_checker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/not_sweep_checker.sv
// Sweeps every N-bit operand through a golden inverter model and an inverter under test, then reports mismatches.
// Optional macro SWEEP_STOP_ON_FAIL_EN: end the sweep as soon as the first mismatch is counted.
module not_sweep_checker #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   output logic [N-1:0] operand_out,
   input  logic [N-1:0] golden_in,
   input  logic [N-1:0] dut_in,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic [N:0]   err_count,
   output logic         first_fail_valid,
   output logic [N-1:0] first_fail_operand
);

   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

   localparam logic [N-1:0] ALL_ONES = '1;
   localparam logic [N:0]   ONE_CNT  = {{N{1'b0}}, 1'b1};

   state_t       state_q, state_d;
   logic [N-1:0] operand_q, operand_d;
   logic         s1_valid_q, s1_valid_d;
   logic         s1_mis_q, s1_mis_d;
   logic [N-1:0] s1_op_q, s1_op_d;
   logic [N:0]   err_count_q, err_count_d;
   logic         ffv_q, ffv_d;
   logic [N-1:0] ffo_q, ffo_d;
   logic         consume;

   assign consume = s1_valid_q && s1_mis_q;

   always_comb begin
      state_d     = state_q;
      operand_d   = operand_q;
      s1_valid_d  = s1_valid_q;
      s1_mis_d    = s1_mis_q;
      s1_op_d     = s1_op_q;
      err_count_d = err_count_q;
      ffv_d       = ffv_q;
      ffo_d       = ffo_q;

      // Stage 2: fold the registered compare result into the error record.
      if (consume) begin
         err_count_d = err_count_q + ONE_CNT;
         if (!ffv_q) begin
            ffv_d = 1'b1;
            ffo_d = s1_op_q;
         end
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = SWEEP;
               operand_d   = '0;
               s1_valid_d  = 1'b0;
               err_count_d = '0;
               ffv_d       = 1'b0;
               ffo_d       = '0;
            end
         end
         SWEEP: begin
            s1_valid_d = 1'b1;
            s1_mis_d   = (golden_in != dut_in);
            s1_op_d    = operand_q;
            if (operand_q == ALL_ONES) begin
               state_d = DRAIN;
            end else begin
               operand_d = operand_q + 1'b1;
            end
         end
         DRAIN: begin
            s1_valid_d = 1'b0;
            state_d    = DONE;
         end
         default: state_d = IDLE;
      endcase

`ifdef SWEEP_STOP_ON_FAIL_EN
      // The first counted mismatch ends the run; the result already in stage 1 is dropped.
      if ((state_q == SWEEP || state_q == DRAIN) && consume && !ffv_q) begin
         state_d    = DONE;
         s1_valid_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         operand_q   <= '0;
         s1_valid_q  <= 1'b0;
         s1_mis_q    <= 1'b0;
         s1_op_q     <= '0;
         err_count_q <= '0;
         ffv_q       <= 1'b0;
         ffo_q       <= '0;
      end else begin
         state_q     <= state_d;
         operand_q   <= operand_d;
         s1_valid_q  <= s1_valid_d;
         s1_mis_q    <= s1_mis_d;
         s1_op_q     <= s1_op_d;
         err_count_q <= err_count_d;
         ffv_q       <= ffv_d;
         ffo_q       <= ffo_d;
      end
   end

   assign operand_out        = operand_q;
   assign busy               = (state_q == SWEEP) || (state_q == DRAIN);
   assign done               = (state_q == DONE);
   assign pass               = done && (err_count_q == '0);
   assign err_count          = err_count_q;
   assign first_fail_valid   = ffv_q;
   assign first_fail_operand = ffo_q;

endmodule

// File: tb/tb_not_sweep_checker.sv
// Bench for not_sweep_checker (N=4): the inverter under test is modelled as ~a with a per-operand xor fault table.
module tb_not_sweep_checker;

   localparam int N = 4;
   localparam int NOPS = 1 << N;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [N-1:0] operand_out;
   logic [N-1:0] golden_in;
   logic [N-1:0] dut_in;
   logic         busy, done, pass;
   logic [N:0]   err_count;
   logic         first_fail_valid;
   logic [N-1:0] first_fail_operand;

   logic [N-1:0] mask_tab [NOPS];

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   assign golden_in = ~operand_out;
   assign dut_in    = ~operand_out ^ mask_tab[operand_out];

   not_sweep_checker #(.N(N)) dut (
      .clk                (clk),
      .reset              (reset),
      .start              (start),
      .operand_out        (operand_out),
      .golden_in          (golden_in),
      .dut_in             (dut_in),
      .busy               (busy),
      .done               (done),
      .pass               (pass),
      .err_count          (err_count),
      .first_fail_valid   (first_fail_valid),
      .first_fail_operand (first_fail_operand)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic clear_tab();
      for (int i = 0; i < NOPS; i++) mask_tab[i] = '0;
   endtask

   // Expected sweep outcome derived directly from the fault table.
   task automatic model(output int e_err, output int e_ffv, output int e_ffo, output int e_lat);
      e_err = 0; e_ffv = 0; e_ffo = 0;
      for (int i = 0; i < NOPS; i++) begin
         if (mask_tab[i] != '0) begin
            e_err++;
            if (e_ffv == 0) begin
               e_ffv = 1;
               e_ffo = i;
            end
         end
      end
      e_lat = NOPS + 1;
`ifdef SWEEP_STOP_ON_FAIL_EN
      if (e_ffv != 0) begin
         e_err = 1;
         e_lat = e_ffo + 2;
      end
`endif
   endtask

   task automatic wait_done(inout int lat);
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic check_result(input string tag, input int lat);
      int e_err, e_ffv, e_ffo, e_lat;
      model(e_err, e_ffv, e_ffo, e_lat);
      chk({tag, "_lat"}, lat, e_lat);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_pass"}, pass, (e_err == 0));
      chk({tag, "_err"}, err_count, e_err);
      chk({tag, "_ffv"}, first_fail_valid, e_ffv);
      chk({tag, "_ffo"}, first_fail_operand, e_ffo);
   endtask

   task automatic run_sweep(input string tag);
      int lat;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_busy0"}, busy, 1);
      chk({tag, "_done0"}, done, 0);
      lat = 0;
      wait_done(lat);
      check_result(tag, lat);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_op"}, operand_out, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_err"}, err_count, 0);
      chk({tag, "_ffv"}, first_fail_valid, 0);
      chk({tag, "_ffo"}, first_fail_operand, 0);
   endtask

   initial begin
      int lat;
      clear_tab();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("rst");
      reset = 1'b0;
      @(posedge clk); #1;

      // Clean inverter
      run_sweep("clean");

      // Single wrong result: a=5 gives 0
      clear_tab();
      mask_tab[5] = 4'hA;
      run_sweep("single5");

      // bit0 stuck at 0: every even operand has golden bit0 set
      clear_tab();
      for (int i = 0; i < NOPS; i++) mask_tab[i] = ((i % 2) == 0) ? 4'h1 : 4'h0;
      run_sweep("stuck0");

      // Randomised fault tables
      for (int r = 0; r < 6; r++) begin
         clear_tab();
         for (int i = 0; i < NOPS; i++)
            if ($urandom_range(0, 3) == 0) mask_tab[i] = 4'($urandom_range(1, 15));
         run_sweep($sformatf("rand%0d", r));
      end

      // Reset in the middle of a sweep
      clear_tab();
`ifdef SWEEP_STOP_ON_FAIL_EN
      mask_tab[9] = 4'h3;
`else
      mask_tab[3] = 4'h3;
`endif
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      while (operand_out != 4'h7 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("midrst_reach7", operand_out, 4'h7);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_all_zero("midrst");
      clear_tab();
      run_sweep("after_rst");

      // start held high: ignored mid-sweep, immediate rerun from DONE
      clear_tab();
      mask_tab[12] = 4'h8;
      start = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      repeat (4) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("hold_op4", operand_out, 4'h4);
      chk("hold_busy", busy, 1);
      wait_done(lat);
      check_result("hold1", lat);
      @(posedge clk); #1;
      start = 1'b0;
      chk("rerun_done", done, 0);
      chk("rerun_busy", busy, 1);
      chk("rerun_op", operand_out, 0);
      chk("rerun_err", err_count, 0);
      chk("rerun_ffv", first_fail_valid, 0);
      lat = 0;
      wait_done(lat);
      check_result("hold2", lat);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
